// File: rtl/cpu_arb_pkg.sv
// Shared types, constants and helpers for the register-file write-port arbiter.
package cpu_arb_pkg;

  localparam int ARB_NREQ  = 4;
  localparam int ARB_IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_NREQ-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_NREQ; i++) begin
      if (oh[i]) idx = i[ARB_IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning from ptr_i upward, wrapping mod 4.
module rr_priority_pick
  import cpu_arb_pkg::*;
(
  input  logic [ARB_NREQ-1:0]  req_i,
  input  logic [ARB_IDX_W-1:0] ptr_i,
  output logic [ARB_NREQ-1:0]  gnt_o,
  output logic [ARB_IDX_W-1:0] idx_o,
  output logic                 any_o
);

  logic [ARB_IDX_W-1:0] k;

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned and infers a latch.
    gnt_o = '0;
    k     = '0;
    for (int i = 0; i < ARB_NREQ; i++) begin
      k = ptr_i + i[ARB_IDX_W-1:0];
      if (req_i[k] && (gnt_o == '0)) gnt_o[k] = 1'b1;
    end
  end

  assign idx_o = onehot_to_idx(gnt_o);
  assign any_o = |req_i;

endmodule

// File: rtl/regwr_port_arbiter.sv
// Round-robin arbiter for the register-file write port; four write-back sources.
// Optional grant lock (lock_i) is built when ARB_LOCK_EN is defined.
module regwr_port_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int NREQ   = ARB_NREQ
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NREQ*DATA_W-1:0]   req_data_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [ARB_IDX_W-1:0]     sel_o,
  output logic [NREQ-1:0]          done_o,
  output logic                     wr_valid_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [DATA_W-1:0]        wr_data_o,
  input  logic                     wr_ready_i
`ifdef ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]          lock_i
`endif
);

  arb_state_e           state_q, state_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [ARB_IDX_W-1:0] sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;

  logic                 hs;
  logic [NREQ-1:0]      elig;
  logic [NREQ-1:0]      win_oh;
  logic [ARB_IDX_W-1:0] win_idx;
  logic                 win_any;
  logic                 lock_hold;
  logic                 load;
  logic [ARB_IDX_W-1:0] load_idx;

  assign hs   = valid_q & wr_ready_i;
  // The finishing winner must not win again on its own handshake edge.
  assign elig = req_i & ~(hs ? gnt_q : '0);

`ifdef ARB_LOCK_EN
  assign lock_hold = lock_i[sel_q] & req_i[sel_q];
`else
  assign lock_hold = 1'b0;
`endif

  rr_priority_pick u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    load     = 1'b0;
    load_idx = win_idx;

    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          load    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (hs) begin
          if (lock_hold) begin
            load     = 1'b1;
            load_idx = sel_q;
          end else begin
            ptr_d = sel_q + 2'd1;
            if (win_any) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              gnt_d   = '0;
            end
          end
        end
      end
    endcase

    if (load) begin
      valid_d         = 1'b1;
      sel_d           = load_idx;
      gnt_d           = '0;
      gnt_d[load_idx] = 1'b1;
      addr_d          = req_addr_i[load_idx*ADDR_W +: ADDR_W];
      data_d          = req_data_i[load_idx*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign sel_o      = sel_q;
  assign wr_valid_o = valid_q;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign done_o     = gnt_q & {NREQ{hs}};

endmodule

// File: tb/tb_regwr_port_arbiter.sv
// Scoreboard bench for regwr_port_arbiter: directed stimulus pushes expected writes, a monitor checks each handshake.
module tb_regwr_port_arbiter;

  typedef struct packed {
    logic [1:0]  sel;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [11:0] req_addr_i;
  logic [63:0] req_data_i;
  logic [3:0]  gnt_o;
  logic [1:0]  sel_o;
  logic [3:0]  done_o;
  logic        wr_valid_o;
  logic [2:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        wr_ready_i;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock_i;
`endif

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  regwr_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .gnt_o      (gnt_o),
    .sel_o      (sel_o),
    .done_o     (done_o),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .wr_ready_i (wr_ready_i)
`ifdef ARB_LOCK_EN
    ,
    .lock_i     (lock_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [2:0] addr, input logic [15:0] data);
    req_addr_i[k*3 +: 3]   = addr;
    req_data_i[k*16 +: 16] = data;
  endtask

  task automatic push(input logic [1:0] sel, input logic [2:0] addr, input logic [15:0] data);
    exp_t e;
    e.sel  = sel;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every accepted write must match the next expected transfer.
  always @(negedge clk) begin
    if (rst_n && wr_valid_o && wr_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        logic [3:0] oh;
        e  = sb.pop_front();
        oh = 4'b0001 << e.sel;
        check("mon_sel",  32'(sel_o),     32'(e.sel));
        check("mon_addr", 32'(wr_addr_o), 32'(e.addr));
        check("mon_data", 32'(wr_data_o), 32'(e.data));
        check("mon_gnt",  32'(gnt_o),     32'(oh));
        check("mon_done", 32'(done_o),    32'(oh));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    req_i      = '0;
    req_addr_i = '0;
    req_data_i = '0;
    wr_ready_i = 1'b0;
`ifdef ARB_LOCK_EN
    lock_i     = '0;
`endif
    step();
    step();
    check("rst_gnt",   32'(gnt_o),      32'd0);
    check("rst_sel",   32'(sel_o),      32'd0);
    check("rst_valid", 32'(wr_valid_o), 32'd0);
    check("rst_addr",  32'(wr_addr_o),  32'd0);
    check("rst_data",  32'(wr_data_o),  32'd0);
    check("rst_done",  32'(done_o),     32'd0);
    rst_n = 1'b1;

    // Reset priority: all four request, port always ready -> 0,1,2,3,0.
    for (int k = 0; k < 4; k++) set_req(k, 3'(k + 1), 16'hA0A0 + 16'(k));
    push(2'd0, 3'd1, 16'hA0A0);
    push(2'd1, 3'd2, 16'hA0A1);
    push(2'd2, 3'd3, 16'hA0A2);
    push(2'd3, 3'd4, 16'hA0A3);
    push(2'd0, 3'd1, 16'hA0A0);
    req_i      = 4'b1111;
    wr_ready_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    req_i = 4'b0000;
    step();
    check("rr_idle_valid", 32'(wr_valid_o), 32'd0);
    check("rr_idle_gnt",   32'(gnt_o),      32'd0);

    // Backpressure: requester 2 held for three not-ready cycles.
    set_req(2, 3'd5, 16'hBEEF);
    wr_ready_i = 1'b0;
    req_i      = 4'b0100;
    push(2'd2, 3'd5, 16'hBEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(wr_valid_o), 32'd1);
      check("bp_sel",   32'(sel_o),      32'd2);
      check("bp_addr",  32'(wr_addr_o),  32'd5);
      check("bp_data",  32'(wr_data_o),  32'hBEEF);
      check("bp_done",  32'(done_o),     32'd0);
      if (i < 2) step();
    end
    wr_ready_i = 1'b1;
    #1;
    check("bp_done_pulse", 32'(done_o), 32'b0100);
    step();
    req_i = 4'b0000;
    check("bp_after_valid", 32'(wr_valid_o), 32'd0);
    check("bp_after_done",  32'(done_o),     32'd0);
    check("bp_after_gnt",   32'(gnt_o),      32'd0);
    check("bp_hold_sel",    32'(sel_o),      32'd2);
    check("bp_hold_addr",   32'(wr_addr_o),  32'd5);
    check("bp_hold_data",   32'(wr_data_o),  32'hBEEF);

    // Request change while stalled is not re-sampled.
    set_req(1, 3'd2, 16'h1234);
    req_i      = 4'b0010;
    wr_ready_i = 1'b0;
    push(2'd1, 3'd2, 16'h1234);
    step();
    set_req(1, 3'd7, 16'h5678);
    step();
    check("chg_addr", 32'(wr_addr_o), 32'd2);
    check("chg_data", 32'(wr_data_o), 32'h1234);
    step();
    check("chg_addr2", 32'(wr_addr_o), 32'd2);
    wr_ready_i = 1'b1;
    step();
    req_i = 4'b0000;
    check("chg_idle", 32'(wr_valid_o), 32'd0);

    // Reset mid-transfer: grant 3 stalled, then reset; pointer returns to 0.
    set_req(3, 3'd6, 16'h3333);
    req_i      = 4'b1000;
    wr_ready_i = 1'b0;
    step();
    check("mid_sel", 32'(sel_o), 32'd3);
    rst_n = 1'b0;
    step();
    check("mid_rst_gnt",   32'(gnt_o),      32'd0);
    check("mid_rst_valid", 32'(wr_valid_o), 32'd0);
    check("mid_rst_sel",   32'(sel_o),      32'd0);
    check("mid_rst_addr",  32'(wr_addr_o),  32'd0);
    check("mid_rst_data",  32'(wr_data_o),  32'd0);
    check("mid_rst_done",  32'(done_o),     32'd0);
    rst_n = 1'b1;
    set_req(1, 3'd4, 16'h4444);
    req_i = 4'b1010;
    push(2'd1, 3'd4, 16'h4444);
    push(2'd3, 3'd6, 16'h3333);
    step();
    check("mid_first_sel", 32'(sel_o), 32'd1);
    wr_ready_i = 1'b1;
    step();
    req_i = 4'b1000;
    step();
    req_i = 4'b0000;
    check("mid_idle", 32'(wr_valid_o), 32'd0);

    // Pointer wrap: 3 completes with 3 and 0 requesting -> 0 next.
    set_req(0, 3'd0, 16'h0F0F);
    req_i = 4'b1000;
    push(2'd3, 3'd6, 16'h3333);
    push(2'd0, 3'd0, 16'h0F0F);
    step();
    req_i = 4'b1001;
    step();
    check("wrap_sel", 32'(sel_o), 32'd0);
    req_i = 4'b0000;
    step();
    check("wrap_idle", 32'(wr_valid_o), 32'd0);

`ifdef ARB_LOCK_EN
    // Lock: requester 1 re-granted three times, then release hands over to 2.
    set_req(1, 3'd1, 16'h1111);
    set_req(2, 3'd2, 16'h2222);
    req_i  = 4'b0111;
    lock_i = 4'b0010;
    push(2'd1, 3'd1, 16'h1111);
    step();
    set_req(1, 3'd1, 16'h1112);
    push(2'd1, 3'd1, 16'h1112);
    step();
    set_req(1, 3'd1, 16'h1113);
    push(2'd1, 3'd1, 16'h1113);
    step();
    lock_i = 4'b0000;
    push(2'd2, 3'd2, 16'h2222);
    step();
    check("lock_release_sel", 32'(sel_o), 32'd2);
    req_i = 4'b0000;
    step();
    check("lock_idle", 32'(wr_valid_o), 32'd0);
`endif

    wr_ready_i = 1'b0;
    step();
    step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
